// File: rtl/ripple_pkg.sv
// ----------------------------------------------------------------------------
// ripple_pkg
// Shared definitions for the ripple counter sampler:
//   CNT_W_DEF     default width of the asynchronous ripple counter input
//   snap_state_e  encoding of the snapshot handshake state machine
// ----------------------------------------------------------------------------
package ripple_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_e;

endpackage : ripple_pkg

// File: rtl/bit_sync.sv
// ----------------------------------------------------------------------------
// bit_sync
// Per-bit multi-flop synchroniser. Each bit of i_d is passed independently
// through STAGES flops. Bits are not kept coherent with each other; the
// consumer must filter out skewed combinations.
// Ports:
//   clock    in   1      destination clock
//   reset_n  in   1      asynchronous active-low reset, clears the chain
//   i_d      in   WIDTH  asynchronous input bits
//   o_q      out  WIDTH  synchronised bits (last stage)
// ----------------------------------------------------------------------------
module bit_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value; blocking ones would collapse the chain into one flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule : bit_sync

// File: rtl/ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// ripple_count_sampler
// Samples a free-running asynchronous ripple counter, drops intermediate
// ripple values, and extends the count into a wide accumulator. A snapshot
// of the accumulator is offered over a valid/ready handshake.
// Ports:
//   clock       in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   cnt_in      in   CNT_W  raw ripple counter value
//   clr         in   1      synchronous clear of ext_count and ovf
//   snap_req    in   1      request to capture ext_count
//   snap_ready  in   1      consumer ready for snap_data
//   snap_valid  out  1      snapshot available
//   snap_data   out  EXT_W  captured ext_count
//   ext_count   out  EXT_W  live extended count
//   wrap_pulse  out  1      accepted counter value wrapped past zero
//   snap_drop   out  1      snap_req ignored because a snapshot was pending
//   ovf         out  1      sticky accumulator overflow
// ----------------------------------------------------------------------------
module ripple_count_sampler
  import ripple_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EXT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [EXT_W-1:0] snap_data,
  output logic [EXT_W-1:0] ext_count,
  output logic             wrap_pulse,
  output logic             snap_drop,
  output logic             ovf
);

  logic [CNT_W-1:0]   w_s;
  logic [CNT_W-1:0]   r_p;
  logic [CNT_W-1:0]   r_acc;
  logic               r_init;
  logic [SYNC_STAGES:0] r_fill;
  logic [EXT_W-1:0]   r_ext;
  logic               r_ovf;
  logic               r_wrap;
  logic               w_accept;
  logic [CNT_W-1:0]   w_diff;
  logic [EXT_W:0]     w_sum;

  snap_state_e        r_state;
  snap_state_e        w_state_nxt;
  logic               w_capture;
  logic [EXT_W-1:0]   r_snap_data;
  logic               r_drop;

  bit_sync #(
    .WIDTH  (CNT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (cnt_in),
    .o_q     (w_s)
  );

  // r_fill marks which pipeline positions hold real samples since reset.
  // Without it the all-zero reset contents of s and p would look like a
  // stable value 0 and be taken as the baseline.
  assign w_accept = r_fill[SYNC_STAGES] && (w_s == r_p);

  // Modulo-2^CNT_W distance travelled since the last accepted value.
  assign w_diff = w_s - r_acc;
  assign w_sum  = {1'b0, r_ext} + {{(EXT_W+1-CNT_W){1'b0}}, w_diff};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p    <= '0;
      r_acc  <= '0;
      r_init <= 1'b0;
      r_fill <= '0;
      r_ext  <= '0;
      r_ovf  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_p    <= w_s;
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_wrap <= 1'b0;
      if (clr) begin
        // Re-baseline on the current sample so nothing is counted across
        // the clear; an accept in this cycle is discarded.
        r_ext <= '0;
        r_ovf <= 1'b0;
        r_acc <= w_s;
      end else if (w_accept) begin
        r_acc <= w_s;
        if (!r_init) begin
          r_init <= 1'b1;
        end else begin
          r_ext  <= w_sum[EXT_W-1:0];
          r_wrap <= (w_s < r_acc);
          if (w_sum[EXT_W]) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  // Snapshot handshake: next-state logic.
  // NOTE: every signal gets its default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      SNAP_IDLE: begin
        if (snap_req) begin
          w_state_nxt = SNAP_HOLD;
          w_capture   = 1'b1;
        end
      end
      SNAP_HOLD: begin
        if (snap_ready) begin
          w_state_nxt = SNAP_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SNAP_IDLE;
      r_snap_data <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // r_ext here is the value before any same-cycle accumulator update.
      if (w_capture) begin
        r_snap_data <= r_ext;
      end
      r_drop <= snap_req && (r_state == SNAP_HOLD);
    end
  end

  assign snap_valid = (r_state == SNAP_HOLD);
  assign snap_data  = r_snap_data;
  assign ext_count  = r_ext;
  assign wrap_pulse = r_wrap;
  assign snap_drop  = r_drop;
  assign ovf        = r_ovf;

endmodule : ripple_count_sampler

// File: tb/tb_ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// tb_ripple_count_sampler
// Two instances share all inputs: a 16-bit accumulator and an 8-bit one (for
// the overflow case). The reference model works on whole held values: a value
// driven for at least two clock samples is an accepted value; the first one
// after reset is the baseline, later ones add their modulo-16 distance.
// ----------------------------------------------------------------------------
module tb_ripple_count_sampler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  cnt_in = 4'h0;
  logic        clr = 1'b0;
  logic        snap_req = 1'b0;
  logic        snap_ready = 1'b0;

  logic        snap_valid, wrap_pulse, snap_drop, ovf;
  logic [15:0] snap_data, ext_count;
  logic        snap_valid8, wrap_pulse8, snap_drop8, ovf8;
  logic [7:0]  snap_data8, ext_count8;

  ripple_count_sampler #(.CNT_W(4), .EXT_W(16), .SYNC_STAGES(2)) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid),
    .snap_data  (snap_data),
    .ext_count  (ext_count),
    .wrap_pulse (wrap_pulse),
    .snap_drop  (snap_drop),
    .ovf        (ovf)
  );

  ripple_count_sampler #(.CNT_W(4), .EXT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid8),
    .snap_data  (snap_data8),
    .ext_count  (ext_count8),
    .wrap_pulse (wrap_pulse8),
    .snap_drop  (snap_drop8),
    .ovf        (ovf8)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit         m_init;
  logic [3:0] m_a;
  int         m_ext16, m_ext8;
  bit         m_ovf16, m_ovf8;
  int         m_wraps = 0;
  logic [3:0] cur = 4'h0;

  int seen_wraps = 0;
  int seen_wraps8 = 0;

  always @(negedge clock) begin
    if (wrap_pulse)  seen_wraps++;
    if (wrap_pulse8) seen_wraps8++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [3:0] v);
    int d;
    if (!m_init) begin
      m_a    = v;
      m_init = 1'b1;
    end else begin
      d = (int'(v) - int'(m_a) + 16) % 16;
      if (v < m_a) m_wraps++;
      m_ext16 += d;
      if (m_ext16 >= 65536) begin m_ext16 -= 65536; m_ovf16 = 1'b1; end
      m_ext8 += d;
      if (m_ext8 >= 256) begin m_ext8 -= 256; m_ovf8 = 1'b1; end
      m_a = v;
    end
  endtask

  // Drive v for n clock samples (called and returning at a negedge).
  task automatic seg(input logic [3:0] v, input int n);
    cnt_in = v;
    cur    = v;
    repeat (n) @(negedge clock);
    if (n >= 2) model_accept(v);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ext16"}, 32'(ext_count), 32'(m_ext16));
    check({tag, "_ext8"},  32'(ext_count8), 32'(m_ext8));
    check({tag, "_ovf16"}, 32'(ovf), 32'(m_ovf16));
    check({tag, "_ovf8"},  32'(ovf8), 32'(m_ovf8));
    check({tag, "_wraps"}, 32'(seen_wraps), 32'(m_wraps));
    check({tag, "_wraps8"}, 32'(seen_wraps8), 32'(m_wraps));
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset_n    = 1'b0;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    clr        = 1'b0;
    #1;
    check({tag, "_rst_ext"},   32'(ext_count), 32'h0);
    check({tag, "_rst_valid"}, 32'(snap_valid), 32'h0);
    check({tag, "_rst_data"},  32'(snap_data), 32'h0);
    check({tag, "_rst_pulse"}, 32'({wrap_pulse, snap_drop, ovf}), 32'h0);
    check({tag, "_rst_ext8"},  32'({ovf8, ext_count8}), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    m_init  = 1'b0;
    m_ext16 = 0;
    m_ext8  = 0;
    m_ovf16 = 1'b0;
    m_ovf8  = 1'b0;
  endtask

  // Call only when cnt_in has been stable long enough to be settled.
  task automatic do_clr();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    m_ext16 = 0;
    m_ext8  = 0;
    m_ovf16 = 1'b0;
    m_ovf8  = 1'b0;
    m_a     = cur;
  endtask

  // Move the counter forward by total counts in random steps of 1..15.
  task automatic advance(input int total);
    int step;
    while (total > 0) begin
      step  = $urandom_range(1, (total > 15) ? 15 : total);
      total -= step;
      seg(4'(cur + 4'(step)), (total == 0) ? 8 : 3);
    end
  endtask

  task automatic snap_seq(input string tag, input logic [15:0] exp16);
    snap_ready = 1'b0;
    snap_req   = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    check({tag, "_valid"}, 32'(snap_valid), 32'h1);
    check({tag, "_data"},  32'(snap_data), 32'(exp16));
    check({tag, "_data8"}, 32'(snap_data8), 32'(exp16[7:0]));
    check({tag, "_nodrop"}, 32'(snap_drop), 32'h0);
    @(negedge clock);
    check({tag, "_hold"}, 32'({snap_valid, snap_data}), 32'({1'b1, exp16}));
    snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    check({tag, "_drop"}, 32'({snap_drop, snap_valid}), 32'h3);
    @(negedge clock);
    check({tag, "_drop_1cyc"}, 32'(snap_drop), 32'h0);
    // Accept and a new request in the same cycle: request is dropped.
    snap_ready = 1'b1;
    snap_req   = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    check({tag, "_accept"}, 32'({snap_valid, snap_drop}), 32'h1);
    @(negedge clock);
    check({tag, "_idle_ready"}, 32'(snap_valid), 32'h0);
    snap_ready = 1'b0;
  endtask

  initial begin
    int w0;
    logic [3:0] v;
    int n;

    // 1: baseline only.
    do_reset("t1");
    w0 = seen_wraps;
    seg(4'h5, 10);
    check("t1_ext", 32'(ext_count), 32'h0);
    check("t1_wrap", 32'(seen_wraps - w0), 32'h0);
    check_all("t1");

    // 2: full lap plus 3 counts.
    do_reset("t2");
    w0 = seen_wraps;
    seg(4'h0, 6);
    for (int i = 1; i < 16; i++) seg(4'(i), 6);
    seg(4'h0, 6);
    seg(4'h3, 6);
    check("t2_ext", 32'(ext_count), 32'd19);
    check("t2_wrap", 32'(seen_wraps - w0), 32'h1);
    check_all("t2");

    // 3: single-cycle glitches are ignored.
    do_reset("t3");
    seg(4'h7, 8);
    seg(4'h3, 1);
    seg(4'hB, 1);
    seg(4'h8, 8);
    check("t3_ext", 32'(ext_count), 32'h1);
    check_all("t3");

    // 4: 8-bit accumulator overflow and clear.
    do_reset("t4");
    seg(4'h0, 6);
    advance(254);
    check("t4_pre", 32'(ext_count8), 32'hFE);
    advance(3);
    check("t4_ovf_ext", 32'(ext_count8), 32'h01);
    check("t4_ovf", 32'(ovf8), 32'h1);
    check("t4_ext16", 32'(ext_count), 32'h101);
    do_clr();
    check("t4_clr", 32'({ovf8, ext_count8}), 32'h0);
    @(negedge clock);
    check_all("t4");

    // 5: snapshot handshake.
    do_reset("t5");
    seg(4'h0, 6);
    advance(66);
    check("t5_ext", 32'(ext_count), 32'h42);
    snap_seq("t5_snap", 16'h0042);
    check_all("t5");

    // 6: reset while a snapshot is pending and a count is in flight.
    snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    check("t6_hold", 32'(snap_valid), 32'h1);
    cnt_in = 4'(cur + 4'h4);
    cur    = cnt_in;
    @(negedge clock);
    do_reset("t6");
    seg(cur, 10);
    check("t6_base", 32'(ext_count), 32'h0);
    check_all("t6");

    // Random segments with clears and snapshots sprinkled in.
    do_reset("rnd");
    seg(4'($urandom_range(0, 15)), 6);
    for (int k = 0; k < 300; k++) begin
      do v = 4'($urandom_range(0, 15)); while (v == cur);
      n = $urandom_range(1, 8);
      seg(v, n);
      if (n >= 6) begin
        check_all($sformatf("rnd%0d", k));
        if ($urandom_range(0, 9) == 0) begin
          do_clr();
          check_all($sformatf("rnd%0d_clr", k));
        end
        if ($urandom_range(0, 7) == 0) begin
          snap_req = 1'b1;
          @(negedge clock);
          snap_req = 1'b0;
          check($sformatf("rnd%0d_snap", k), 32'(snap_data), 32'(m_ext16));
          snap_ready = 1'b1;
          @(negedge clock);
          snap_ready = 1'b0;
          check($sformatf("rnd%0d_snap_done", k), 32'(snap_valid), 32'h0);
        end
      end
    end
    seg(4'(cur + 4'h1), 8);
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ripple_count_sampler
